mem_copy_master: RTL and testbench

MEM_COPY_MASTER -- requirements
Module: mem_copy_master

---
 rtl/mem_bus_pkg.sv | 17 +
 rtl/mem_copy_master_if.sv | 24 ++
 rtl/mem_copy_master.sv | 146 ++++++++++++++
 tb/tb_mem_copy_master.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared memory-bus constants and the copy-engine state encoding.
package mem_bus_pkg;

    localparam logic [3:0]  WSTRB_READ = 4'b0000;
    localparam logic [3:0]  WSTRB_WORD = 4'b1111;
    localparam logic [31:0] WORD_BYTES = 32'd4;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_GAP,
        WR,
        WR_GAP,
        DONE
    } copy_state_e;

endpackage

// File: rtl/mem_copy_master_if.sv
// Single-beat word bus between the copy master and a memory responder.
interface mem_copy_master_if;

    // Handshake: the master holds mem_valid with stable mem_addr/mem_wdata/mem_wstrb
    // until it samples mem_ready=1 on a rising edge; that edge completes the beat and
    // mem_rdata is meaningful only in the cycle mem_ready is high.
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/mem_copy_master.sv
// Word-by-word memory copy engine (read, gap, write, gap); optional fill mode
// is built only when MEM_COPY_FILL_EN is defined.
module mem_copy_master
    import mem_bus_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [31:0]          src_addr,
    input  logic [31:0]          dst_addr,
    input  logic [LEN_W-1:0]     len_words,
    input  logic                 fill_mode,
    input  logic [31:0]          fill_value,
    output logic                 busy,
    output logic                 done,
    output copy_state_e          dbg_state,
    mem_copy_master_if.master    bus
);

    copy_state_e      state_q, state_d;
    logic [31:0]      src_q, src_d, dst_q, dst_d, data_q, data_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [31:0]      addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic             fill_sel;
    logic [31:0]      fill_word;

`ifdef MEM_COPY_FILL_EN
    logic        fill_q, fill_d;
    logic [31:0] fill_val_q, fill_val_d;

    always_comb begin
        fill_d     = fill_q;
        fill_val_d = fill_val_q;
        if (state_q == IDLE && start) begin
            fill_d     = fill_mode;
            fill_val_d = fill_value;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fill_q     <= 1'b0;
            fill_val_q <= '0;
        end else begin
            fill_q     <= fill_d;
            fill_val_q <= fill_val_d;
        end
    end

    // The "_d" view lets the start cycle pick WR and its data directly from the inputs.
    assign fill_sel  = fill_d;
    assign fill_word = fill_val_d;
`else
    logic unused_fill;
    assign unused_fill = ^{fill_mode, fill_value};
    assign fill_sel    = 1'b0;
    assign fill_word   = '0;
`endif

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        data_d  = data_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    src_d = {src_addr[31:2], 2'b00};
                    dst_d = {dst_addr[31:2], 2'b00};
                    rem_d = len_words;
                    if (len_words == '0)  state_d = DONE;
                    else if (fill_sel)    state_d = WR;
                    else                  state_d = RD;
                end
            end
            RD: begin
                if (bus.mem_ready) begin
                    data_d  = bus.mem_rdata;
                    state_d = RD_GAP;
                end
            end
            RD_GAP: state_d = WR;
            WR: begin
                if (bus.mem_ready) begin
                    rem_d   = rem_q - LEN_W'(1);
                    src_d   = src_q + WORD_BYTES;
                    dst_d   = dst_q + WORD_BYTES;
                    state_d = (rem_q == LEN_W'(1)) ? DONE : WR_GAP;
                end
            end
            WR_GAP: state_d = fill_sel ? WR : RD;
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Bus fields are loaded only on entry to an access state so they hold while waiting.
        if (state_d == RD && state_q != RD) begin
            addr_d  = src_d;
            wstrb_d = WSTRB_READ;
        end
        if (state_d == WR && state_q != WR) begin
            addr_d  = dst_d;
            wstrb_d = WSTRB_WORD;
            wdata_d = fill_sel ? fill_word : data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= WSTRB_READ;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

    assign bus.mem_valid = (state_q == RD) || (state_q == WR);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wstrb = wstrb_q;
    assign busy          = (state_q == RD) || (state_q == RD_GAP) ||
                           (state_q == WR) || (state_q == WR_GAP);
    assign done          = (state_q == DONE);
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_copy_master.sv
// Scoreboard bench for mem_copy_master: directed commands, a delayed-ready responder
// that also acts as the bus monitor, and an expected-transaction queue.
module tb_mem_copy_master;
    import mem_bus_pkg::*;

    localparam int LEN_W      = 16;
    localparam int RESP_DELAY = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [31:0]       src_addr = '0;
    logic [31:0]       dst_addr = '0;
    logic [LEN_W-1:0]  len_words = '0;
    logic              fill_mode = 1'b0;
    logic [31:0]       fill_value = '0;
    logic              busy, done;
    copy_state_e       dbg_state;

    mem_copy_master_if bus ();

    mem_copy_master #(.LEN_W(LEN_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len_words  (len_words),
        .fill_mode  (fill_mode),
        .fill_value (fill_value),
        .busy       (busy),
        .done       (done),
        .dbg_state  (dbg_state),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [67:0] exp_q[$];
    logic [31:0] mem_img [logic [31:0]];
    int n_cmp = 0;
    int n_err = 0;
    int busy_total = 0;
    int done_total = 0;
    int wr_rise_total = 0;

    function automatic logic [67:0] txn(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        return {w, a, d};
    endfunction

    function automatic logic [31:0] rd_img(input logic [31:0] a);
        return mem_img.exists(a) ? mem_img[a] : 32'h0;
    endfunction

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_rw(input logic [31:0] ra, input logic [31:0] wa, input logic [31:0] d);
        exp_q.push_back(txn(WSTRB_READ, ra, 32'h0));
        exp_q.push_back(txn(WSTRB_WORD, wa, d));
    endtask

    // ---------------- responder + monitor ----------------
    int          resp_cnt = 0;
    logic [67:0] held;
    logic [67:0] observed;

    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
    end

    always @(negedge clk) begin
        if (bus.mem_ready) begin
            bus.mem_ready = 1'b0;
            resp_cnt = 0;
        end else if (bus.mem_valid) begin
            resp_cnt++;
            if (resp_cnt == 1) begin
                held = txn(bus.mem_wstrb, bus.mem_addr, bus.mem_wdata);
                if (bus.mem_wstrb == WSTRB_WORD) wr_rise_total++;
            end else begin
                check("bus_stable", txn(bus.mem_wstrb, bus.mem_addr, bus.mem_wdata), held);
            end
            if (resp_cnt == RESP_DELAY + 1) begin
                bus.mem_ready = 1'b1;
                observed = txn(bus.mem_wstrb, bus.mem_addr,
                               (bus.mem_wstrb == WSTRB_READ) ? 32'h0 : bus.mem_wdata);
                if (bus.mem_wstrb == WSTRB_READ) bus.mem_rdata = rd_img(bus.mem_addr);
                else mem_img[bus.mem_addr] = bus.mem_wdata;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_txn: got %0h expected none", observed);
                end else begin
                    check("bus_txn", observed, exp_q.pop_front());
                end
            end
        end else begin
            resp_cnt = 0;
        end
        if (busy) busy_total++;
        if (done) begin
            done_total++;
            check("done_not_busy", {67'h0, busy}, 68'h0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_start(input logic [31:0] s, input logic [31:0] d,
                            input logic [LEN_W-1:0] n, input logic fm, input logic [31:0] fv);
        @(negedge clk);
        src_addr = s; dst_addr = d; len_words = n; fill_mode = fm; fill_value = fv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int k = 0;
        while (done !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL %s: done not seen within %0d cycles", name, budget);
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    int b0, d0, w0, k;
    logic [31:0] fill_exp0, fill_exp1;

    initial begin
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_valid", {67'h0, bus.mem_valid}, 68'h0);
        check("rst_busy",  {67'h0, busy}, 68'h0);
        check("rst_done",  {67'h0, done}, 68'h0);
        check("rst_wstrb", bus.mem_wstrb, 68'h0);
        check("rst_addr",  bus.mem_addr, 68'h0);
        check("rst_wdata", bus.mem_wdata, 68'h0);
        check("rst_state", dbg_state, IDLE);

        // Basic 3-word copy: 12 busy cycles per word less the final write gap.
        mem_img[32'h100] = 32'hA; mem_img[32'h104] = 32'hB; mem_img[32'h108] = 32'hC;
        push_rw(32'h100, 32'h200, 32'hA);
        push_rw(32'h104, 32'h204, 32'hB);
        push_rw(32'h108, 32'h208, 32'hC);
        b0 = busy_total; d0 = done_total;
        do_start(32'h100, 32'h200, 3, 1'b0, 32'h0);
        wait_done(200, "copy3_done");
        check("copy3_busy_cycles", busy_total - b0, 3 * (2 * (RESP_DELAY + 1) + 2) - 1);
        check("copy3_done_pulses", done_total - d0, 1);
        check("copy3_dst0", rd_img(32'h200), 32'hA);
        check("copy3_dst1", rd_img(32'h204), 32'hB);
        check("copy3_dst2", rd_img(32'h208), 32'hC);
        check("copy3_queue_empty", exp_q.size(), 0);

        // Zero-length command goes straight to DONE.
        b0 = busy_total; d0 = done_total;
        do_start(32'h10, 32'h20, 0, 1'b0, 32'h0);
        check("len0_done",  {67'h0, done}, 68'h1);
        check("len0_busy",  {67'h0, busy}, 68'h0);
        check("len0_valid", {67'h0, bus.mem_valid}, 68'h0);
        @(negedge clk);
        check("len0_done_drop", {67'h0, done}, 68'h0);
        check("len0_busy_total", busy_total - b0, 0);
        check("len0_done_pulses", done_total - d0, 1);

        // Unaligned source and destination wrap past 2^32.
        mem_img[32'h100] = 32'h11; mem_img[32'h104] = 32'h22;
        push_rw(32'h100, 32'hFFFF_FFFC, 32'h11);
        push_rw(32'h104, 32'h0000_0000, 32'h22);
        do_start(32'h103, 32'hFFFF_FFFC, 2, 1'b0, 32'h0);
        wait_done(200, "wrap_done");
        check("wrap_dst_top", rd_img(32'hFFFF_FFFC), 32'h11);
        check("wrap_dst_zero", rd_img(32'h0), 32'h22);
        check("wrap_queue_empty", exp_q.size(), 0);

        // A second start while busy must be ignored.
        mem_img[32'h300] = 32'h33; mem_img[32'h304] = 32'h44;
        push_rw(32'h300, 32'h400, 32'h33);
        push_rw(32'h304, 32'h404, 32'h44);
        d0 = done_total;
        do_start(32'h300, 32'h400, 2, 1'b0, 32'h0);
        repeat (7) @(negedge clk);
        do_start(32'h500, 32'h600, 1, 1'b0, 32'h0);
        wait_done(200, "ignore_done");
        check("ignore_done_pulses", done_total - d0, 1);
        check("ignore_dst0", rd_img(32'h400), 32'h33);
        check("ignore_dst1", rd_img(32'h404), 32'h44);
        check("ignore_no_write", {67'h0, mem_img.exists(32'h600)}, 68'h0);
        check("ignore_queue_empty", exp_q.size(), 0);

        // Reset during the second write of a 4-word copy.
        mem_img[32'h700] = 32'h71; mem_img[32'h704] = 32'h72;
        mem_img[32'h708] = 32'h73; mem_img[32'h70C] = 32'h74;
        push_rw(32'h700, 32'h800, 32'h71);
        exp_q.push_back(txn(WSTRB_READ, 32'h704, 32'h0));
        d0 = done_total; w0 = wr_rise_total;
        do_start(32'h700, 32'h800, 4, 1'b0, 32'h0);
        k = 0;
        while (wr_rise_total - w0 < 2 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("abort_reached_wr2", {67'h0, (wr_rise_total - w0 >= 2)}, 68'h1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("abort_valid", {67'h0, bus.mem_valid}, 68'h0);
        check("abort_busy",  {67'h0, busy}, 68'h0);
        check("abort_addr",  bus.mem_addr, 68'h0);
        check("abort_state", dbg_state, IDLE);
        repeat (30) @(negedge clk);
        check("abort_no_done", done_total - d0, 0);
        check("abort_no_wr2", {67'h0, mem_img.exists(32'h804)}, 68'h0);
        check("abort_queue_empty", exp_q.size(), 0);

        mem_img[32'h900] = 32'h99;
        push_rw(32'h900, 32'hA00, 32'h99);
        d0 = done_total;
        do_start(32'h900, 32'hA00, 1, 1'b0, 32'h0);
        wait_done(200, "post_abort_done");
        check("post_abort_dst", rd_img(32'hA00), 32'h99);
        check("post_abort_done_pulses", done_total - d0, 1);
        check("post_abort_queue_empty", exp_q.size(), 0);

        // Fill command: writes the pattern when built with fill, otherwise copies.
        mem_img[32'hB00] = 32'h55; mem_img[32'hB04] = 32'h66;
`ifdef MEM_COPY_FILL_EN
        exp_q.push_back(txn(WSTRB_WORD, 32'h40, 32'hDEAD_BEEF));
        exp_q.push_back(txn(WSTRB_WORD, 32'h44, 32'hDEAD_BEEF));
        fill_exp0 = 32'hDEAD_BEEF; fill_exp1 = 32'hDEAD_BEEF;
`else
        push_rw(32'hB00, 32'h40, 32'h55);
        push_rw(32'hB04, 32'h44, 32'h66);
        fill_exp0 = 32'h55; fill_exp1 = 32'h66;
`endif
        do_start(32'hB00, 32'h40, 2, 1'b1, 32'hDEAD_BEEF);
        wait_done(200, "fill_done");
        check("fill_dst0", rd_img(32'h40), fill_exp0);
        check("fill_dst1", rd_img(32'h44), fill_exp1);
        check("fill_queue_empty", exp_q.size(), 0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
